// File: rtl/fp2_arb_pkg.sv
// Shared types for the fp2 sub/add unit arbiter: FSM states, requester index,
// command width default and the command encodings understood by fp2_sub_add_correction.
package fp2_arb_pkg;

  localparam int unsigned CMD_W_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } arb_state_t;

  typedef logic req_idx_t;

  localparam logic [CMD_W_DEF-1:0] CMD_SUB      = 3'd0;
  localparam logic [CMD_W_DEF-1:0] CMD_ADD      = 3'd1;
  localparam logic [CMD_W_DEF-1:0] CMD_SUB_CORR = 3'd2;
  localparam logic [CMD_W_DEF-1:0] CMD_ADD_CORR = 3'd3;
  localparam logic [CMD_W_DEF-1:0] CMD_CORR     = 3'd4;

endpackage

// File: rtl/fp2_arb_rr_pick.sv
// Two-way round-robin pick: on contention the requester not served last wins.
module fp2_arb_rr_pick
  import fp2_arb_pkg::*;
(
  input  logic     req_0,
  input  logic     req_1,
  input  req_idx_t last,
  output logic     valid,
  output req_idx_t idx
);

  always_comb begin
    valid = req_0 | req_1;
    if (req_0 && req_1) idx = ~last;
    else                idx = req_1;
  end

endmodule

// File: rtl/fp2_sub_add_arbiter.sv
// Arbitrates two requesters onto one fp2_sub_add_correction unit and its memory ports.
// Optional WAIT watchdog enabled by defining FP2_ARB_TIMEOUT_EN.
module fp2_sub_add_arbiter
  import fp2_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CMD_W          = CMD_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_0,
  input  logic             req_1,
  input  logic [CMD_W-1:0] cmd_0,
  input  logic [CMD_W-1:0] cmd_1,
  input  logic             ext_0,
  input  logic             ext_1,
  output logic             grant_0,
  output logic             grant_1,
  output logic             done_0,
  output logic             done_1,
  output logic             mem_sel,
  output logic             unit_start,
  output logic [CMD_W-1:0] unit_cmd,
  output logic             unit_ext,
  input  logic             unit_busy,
  input  logic             unit_done,
  output logic             busy,
  output logic             timeout_err
);

  arb_state_t state, state_nx;
  req_idx_t   owner;
  req_idx_t   last;
  logic       pick_valid;
  req_idx_t   pick_idx;
  logic       tmo_hit;

  fp2_arb_rr_pick u_pick (
    .req_0 (req_0),
    .req_1 (req_1),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      unit_cmd <= '0;
      unit_ext <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && pick_valid) begin
        owner    <= pick_idx;
        unit_cmd <= pick_idx ? cmd_1 : cmd_0;
        unit_ext <= pick_idx ? ext_1 : ext_0;
      end
      if (state == S_DONE) last <= owner;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (pick_valid) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (unit_done || tmo_hit) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Owner-qualified outputs decode straight from the state register, so they
  // follow reset asynchronously and can never overlap.
  assign busy       = (state != S_IDLE);
  assign grant_0    = busy && (owner == 1'b0);
  assign grant_1    = busy && (owner == 1'b1);
  assign done_0     = (state == S_DONE) && (owner == 1'b0);
  assign done_1     = (state == S_DONE) && (owner == 1'b1);
  assign unit_start = (state == S_ISSUE);
  assign mem_sel    = owner;

`ifdef FP2_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             terr;

  assign tmo_hit = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      terr     <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
      if (tmo_hit && !unit_done) terr <= 1'b1;
    end
  end

  assign timeout_err = terr;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // unit_busy is observation only; never steers the FSM.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, unit_busy, 1'(TIMEOUT_CYCLES)};

endmodule

// File: tb/tb_fp2_sub_add_arbiter.sv
// Self-checking bench for fp2_sub_add_arbiter: vector table, directed corner
// sequences and a randomized run against an operation-level reference model.
module tb_fp2_sub_add_arbiter;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_0 = 1'b0, req_1 = 1'b0;
  logic [2:0] cmd_0 = '0, cmd_1 = '0;
  logic       ext_0 = 1'b0, ext_1 = 1'b0;
  logic       unit_busy = 1'b0, unit_done = 1'b0;
  logic       grant_0, grant_1, done_0, done_1, mem_sel, unit_start, unit_ext, busy, timeout_err;
  logic [2:0] unit_cmd;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  fp2_sub_add_arbiter #(.TIMEOUT_CYCLES(TMO), .CMD_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .req_1(req_1), .cmd_0(cmd_0), .cmd_1(cmd_1),
    .ext_0(ext_0), .ext_1(ext_1),
    .grant_0(grant_0), .grant_1(grant_1), .done_0(done_0), .done_1(done_1),
    .mem_sel(mem_sel), .unit_start(unit_start), .unit_cmd(unit_cmd), .unit_ext(unit_ext),
    .unit_busy(unit_busy), .unit_done(unit_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {g0,g1,d0,d1,start,busy,mem_sel,unit_ext} + unit_cmd
  function automatic logic [10:0] obs();
    return {grant_0, grant_1, done_0, done_1, unit_start, busy, mem_sel, unit_ext, unit_cmd};
  endfunction

  typedef struct {
    logic       rst;
    logic       r0, r1;
    logic [2:0] c0, c1;
    logic       e0, e1;
    logic       ud;
    logic [7:0] exp_flags;
    logic [2:0] exp_cmd;
  } vec_t;

  vec_t vecs[22];

  // Reference model state (operation level)
  int         m_own;
  logic       m_last, m_first, m_done, m_sel, m_ext, m_terr;
  logic [2:0] m_cmd;
  int         m_wcnt;
  logic       s_r0, s_r1, s_e0, s_e1, s_ud;
  logic [2:0] s_c0, s_c1;

  always @(posedge clk) begin
    if (chk_en) begin
      s_r0 = req_0; s_r1 = req_1; s_c0 = cmd_0; s_c1 = cmd_1;
      s_e0 = ext_0; s_e1 = ext_1; s_ud = unit_done;
      if (m_done) begin
        m_last = m_own[0];
        m_own  = -1;
        m_done = 1'b0;
      end else if (m_own < 0) begin
        if (s_r0 || s_r1) begin
          if (s_r0 && s_r1) m_own = (m_last == 1'b1) ? 0 : 1;
          else              m_own = s_r0 ? 0 : 1;
          m_cmd   = (m_own == 0) ? s_c0 : s_c1;
          m_ext   = (m_own == 0) ? s_e0 : s_e1;
          m_sel   = m_own[0];
          m_first = 1'b1;
          m_wcnt  = 0;
        end
      end else if (m_first) begin
        m_first = 1'b0;
      end else begin
        m_wcnt++;
        if (s_ud) m_done = 1'b1;
`ifdef FP2_ARB_TIMEOUT_EN
        else if (m_wcnt == TMO) begin
          m_done = 1'b1;
          m_terr = 1'b1;
        end
`endif
      end
      #1;
      check("rand_cycle", {20'd0, obs(), timeout_err},
            {20'd0, (m_own == 0), (m_own == 1), m_done && (m_own == 0), m_done && (m_own == 1),
             m_first, (m_own >= 0), m_sel, m_ext, m_cmd, m_terr});
    end
  end

  task automatic req_step(inout logic r, inout logic [2:0] c, inout logic e,
                          input logic g, input logic d);
    if (r) begin
      if (d) begin
        if ($urandom_range(0, 1) == 0) r = 1'b0;
        else begin c = 3'($urandom); e = 1'($urandom); end
      end else if (g && $urandom_range(0, 15) == 0) begin
        r = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        c = 3'($urandom);
      end
    end else if ($urandom_range(0, 2) == 0) begin
      r = 1'b1; c = 3'($urandom); e = 1'($urandom);
    end
  endtask

  initial begin
    int   starts, early, n, found;
    logic ok;

    //          rst r0 r1 c0    c1    e0 e1 ud  g g d d s b m x       cmd
    vecs[0]  = '{0, 0, 0, 3'd0, 3'd0, 0, 0, 0, 8'b0000_0000, 3'd0};
    vecs[1]  = '{1, 1, 0, 3'd2, 3'd0, 1, 0, 0, 8'b1000_1101, 3'd2};
    vecs[2]  = '{1, 1, 0, 3'd5, 3'd0, 0, 0, 1, 8'b1000_0101, 3'd2};
    vecs[3]  = '{1, 1, 0, 3'd5, 3'd0, 0, 0, 0, 8'b1000_0101, 3'd2};
    vecs[4]  = '{1, 1, 0, 3'd5, 3'd0, 0, 0, 1, 8'b1010_0101, 3'd2};
    vecs[5]  = '{1, 0, 1, 3'd5, 3'd6, 0, 0, 0, 8'b0000_0001, 3'd2};
    vecs[6]  = '{1, 0, 1, 3'd5, 3'd6, 0, 0, 0, 8'b0100_1110, 3'd6};
    vecs[7]  = '{1, 1, 1, 3'd3, 3'd6, 1, 0, 0, 8'b0100_0110, 3'd6};
    vecs[8]  = '{1, 1, 1, 3'd3, 3'd6, 1, 0, 1, 8'b0101_0110, 3'd6};
    vecs[9]  = '{1, 1, 1, 3'd3, 3'd6, 1, 0, 0, 8'b0000_0010, 3'd6};
    vecs[10] = '{1, 1, 1, 3'd3, 3'd6, 1, 0, 0, 8'b1000_1101, 3'd3};
    vecs[11] = '{1, 1, 1, 3'd3, 3'd6, 1, 0, 1, 8'b1000_0101, 3'd3};
    vecs[12] = '{1, 1, 1, 3'd3, 3'd6, 1, 0, 1, 8'b1010_0101, 3'd3};
    vecs[13] = '{1, 1, 1, 3'd3, 3'd6, 1, 0, 1, 8'b0000_0001, 3'd3};
    vecs[14] = '{1, 1, 1, 3'd3, 3'd6, 1, 0, 0, 8'b0100_1110, 3'd6};
    vecs[15] = '{1, 1, 1, 3'd3, 3'd6, 1, 0, 0, 8'b0100_0110, 3'd6};
    vecs[16] = '{0, 0, 0, 3'd3, 3'd6, 1, 0, 1, 8'b0000_0000, 3'd0};
    vecs[17] = '{1, 0, 1, 3'd3, 3'd4, 0, 0, 0, 8'b0100_1110, 3'd4};
    vecs[18] = '{1, 0, 0, 3'd3, 3'd4, 0, 0, 0, 8'b0100_0110, 3'd4};
    vecs[19] = '{1, 0, 0, 3'd3, 3'd4, 0, 0, 1, 8'b0101_0110, 3'd4};
    vecs[20] = '{1, 0, 0, 3'd3, 3'd4, 0, 0, 1, 8'b0000_0010, 3'd4};
    vecs[21] = '{1, 0, 0, 3'd3, 3'd4, 0, 0, 1, 8'b0000_0010, 3'd4};

    for (int i = 0; i < 22; i++) begin
      rst = vecs[i].rst; req_0 = vecs[i].r0; req_1 = vecs[i].r1;
      cmd_0 = vecs[i].c0; cmd_1 = vecs[i].c1; ext_0 = vecs[i].e0; ext_1 = vecs[i].e1;
      unit_done = vecs[i].ud;
      tick();
      check($sformatf("vec%0d", i), {21'd0, obs()}, {21'd0, vecs[i].exp_flags, vecs[i].exp_cmd});
    end
    unit_done = 1'b0;
    check("vec_timeout_err_clear", {31'd0, timeout_err}, 32'd0);

    // Single operation with a 20-cycle unit latency
    req_0 = 1'b1; cmd_0 = 3'd2; ext_0 = 1'b1;
    tick();
    check("r32_grant", {29'd0, grant_0, unit_start, grant_1}, {29'd0, 3'b110});
    check("r32_cmd_ext", {28'd0, unit_cmd, unit_ext}, {28'd0, 3'd2, 1'b1});
    starts = 1; early = 0;
    for (int i = 1; i < 20; i++) begin
      tick();
      starts += int'(unit_start);
      early  += int'(done_0 || done_1 || !grant_0);
    end
    unit_done = 1'b1;
    tick();
    unit_done = 1'b0;
    check("r32_done_pulse", {30'd0, done_0, grant_0}, {30'd0, 2'b11});
    check("r32_starts", starts, 1);
    check("r32_no_early_done", early, 0);
    req_0 = 1'b0;
    tick();
    check("r32_release", {30'd0, done_0, grant_0}, 32'd0);

    // Reset 5 cycles into WAIT abandons the operation
    req_1 = 1'b1; cmd_1 = 3'd1; ext_1 = 1'b1;
    tick();
    tick();
    repeat (5) tick();
    check("r36_in_wait", {30'd0, grant_1, busy}, {30'd0, 2'b11});
    #2 rst = 1'b0;
    #1;
    check("r36_async", {20'd0, obs(), timeout_err}, 32'd0);
    req_1 = 1'b0;
    ok = 1'b1;
    repeat (2) begin
      tick();
      ok &= !(done_0 || done_1 || grant_0 || grant_1);
    end
    check("r36_no_done", {31'd0, ok}, 32'd1);
    rst = 1'b1; req_0 = 1'b1; cmd_0 = 3'd7; ext_0 = 1'b0;
    tick();
    check("r36_after", {21'd0, obs()}, {21'd0, 8'b1000_1100, 3'd7});
    tick();
    unit_done = 1'b1;
    tick();
    unit_done = 1'b0; req_0 = 1'b0;
    check("r36_after_done", {31'd0, done_0}, 32'd1);
    tick();

    // Unit never completes
    req_0 = 1'b1; cmd_0 = 3'd4;
    tick();
    found = 0; n = 0;
    for (int i = 1; i <= 40 && found == 0; i++) begin
      tick();
      if (done_0) begin found = 1; n = i; end
    end
`ifdef FP2_ARB_TIMEOUT_EN
    check("tmo_done_seen", found, 1);
    check("tmo_cycles", n, 17);
    check("tmo_err_set", {31'd0, timeout_err}, 32'd1);
    req_0 = 1'b0;
    tick();
    check("tmo_idle_sticky", {30'd0, busy, timeout_err}, {30'd0, 2'b01});
`else
    check("tmo_no_done", found, 0);
    check("tmo_still_wait", {29'd0, busy, grant_0, timeout_err}, {29'd0, 3'b110});
    req_0 = 1'b0;
`endif
    rst = 1'b0;
    tick();
    check("tmo_reset_clears", {30'd0, busy, timeout_err}, 32'd0);

    // Randomized traffic against the reference model
    m_own = -1; m_last = 1'b1; m_first = 1'b0; m_done = 1'b0; m_sel = 1'b0;
    m_ext = 1'b0; m_terr = 1'b0; m_cmd = '0; m_wcnt = 0;
    rst = 1'b1;
    chk_en = 1'b1;
    repeat (1500) begin
      @(negedge clk);
      req_step(req_0, cmd_0, ext_0, grant_0, done_0);
      req_step(req_1, cmd_1, ext_1, grant_1, done_1);
      unit_done = ($urandom_range(0, 4) == 0);
      unit_busy = 1'($urandom);
    end
    @(negedge clk);
    chk_en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp2_sub_add_arbiter.md
FP2_SUB_ADD_ARBITER -- requirements
Module: fp2_sub_add_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, max unit_start-to-unit_done cycles before abort.
REQ-002 SHALL have parameter CMD_W, default 3, width of the sub/add/correction command.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req_0/req_1  in  1  level request from requester 0/1, held high until its done pulse.
REQ-006 SHALL have ports cmd_0/cmd_1  in  CMD_W  command of requester 0/1, valid while req high.
REQ-007 SHALL have ports ext_0/ext_1  in  1  extension_field_op of requester 0/1.
REQ-008 SHALL have ports grant_0/grant_1  out  1  requester owns the unit and its memory ports.
REQ-009 SHALL have ports done_0/done_1  out  1  one-cycle completion pulse to requester.
REQ-010 SHALL have port mem_sel  out  1  owner index, drives external memory-port muxes.
REQ-011 SHALL have ports unit_start  out  1, unit_cmd  out  CMD_W, unit_ext  out  1  to fp2_sub_add_correction.
REQ-012 SHALL have ports unit_busy  in  1, unit_done  in  1  from fp2_sub_add_correction.
REQ-013 SHALL have port busy  out  1  high in any state except IDLE.
REQ-014 SHALL have port timeout_err  out  1  sticky abort flag.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-016 IDLE: if any req high at edge k, SHALL enter ISSUE at k+1 with grant_x=1, mem_sel=x, unit_cmd/unit_ext latched from cmd_x/ext_x.
REQ-017 Both req high in IDLE: SHALL grant the requester not served last (round-robin pointer, reset value 1, so requester 0 wins first).
REQ-018 ISSUE: unit_start SHALL be high exactly one cycle, then WAIT.
REQ-019 WAIT: on unit_done=1 SHALL enter DONE; done_x SHALL pulse one cycle in DONE; grant_x stays high through DONE.
REQ-020 DONE -> IDLE unconditionally; grant drops, rr pointer updates to x; minimum request-to-request turnaround 4 cycles.
REQ-021 unit_cmd, unit_ext, mem_sel SHALL be stable from ISSUE through DONE, regardless of cmd_x/ext_x changes.
REQ-022 req_x dropped mid-operation: operation SHALL complete, done_x still pulses.
REQ-023 req_x still high in IDLE after its done: SHALL be treated as a new request.
REQ-024 unit_done outside WAIT SHALL be ignored; unit_busy is observation only, not used for transitions.
REQ-025 grant_0 and grant_1 SHALL never be high together; done_x SHALL only pulse with grant_x high.

Reset
REQ-026 rst low SHALL asynchronously force IDLE; grant_*, done_*, unit_start, unit_cmd, unit_ext, mem_sel, busy, timeout_err = 0; rr pointer = 1; timeout counter = 0.
REQ-027 Reset mid-operation SHALL abandon the operation with no done pulse; unit is reset by the same rst.

Configuration
REQ-028 With FP2_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT; at TIMEOUT_CYCLES without unit_done SHALL set timeout_err (sticky until reset) and enter DONE (done_x pulses).
REQ-029 Without FP2_ARB_TIMEOUT_EN, WAIT SHALL last until unit_done, no counter SHALL exist, timeout_err tied 0.

Structure
REQ-030 Package fp2_arb_pkg SHALL hold the state enum, CMD_W default, requester-index type, and the command encodings shared with fp2_sub_add_correction.
REQ-031 Round-robin pick SHALL be sub-module fp2_arb_rr_pick (inputs req_0, req_1, last; outputs valid, idx), combinational.

Verification
REQ-032 req_0=1, cmd_0=3'd2, ext_0=1; unit model asserts done 20 cycles after start -> grant_0 at k+1, one unit_start, unit_cmd=2, unit_ext=1, done_0 one cycle, grant_0 low next cycle.
REQ-033 req_0 and req_1 rise on the same edge after reset -> requester 0 served first, then requester 1; mem_sel 0 then 1; grants never overlap.
REQ-034 req_0 held high continuously with req_1 high -> alternating grants 0,1,0,1 over four operations.
REQ-035 cmd_0 changed from 2 to 5 during WAIT -> unit_cmd stays 2 until DONE.
REQ-036 rst low 5 cycles into WAIT -> all outputs 0 immediately, no done pulse, next req served normally.
REQ-037 FP2_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, unit never done -> timeout_err=1 after 16 WAIT cycles, done_0 pulses, FSM returns to IDLE; without macro FSM stays in WAIT.
